// File: rtl/sram_zbt_phy_if.sv
// Request/response bundle between the SRAM arbiter (master) and the ZBT PHY (slave).
// A request transfers on a cycle where sram_addr_valid and sram_ready are both 1; sram_data_out_valid is a one-cycle pulse with no back-pressure.
interface sram_zbt_phy_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
);
  logic                    sram_addr_valid;
  logic                    sram_ready;
  logic [ADDR_WIDTH-1:0]   sram_addr;
  logic [DATA_WIDTH-1:0]   sram_data_in;
  logic [DATA_WIDTH/8-1:0] sram_write_mask;
  logic [DATA_WIDTH-1:0]   sram_data_out;
  logic                    sram_data_out_valid;
  logic                    dropped_req;

  modport master (
    output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    input  sram_ready, sram_data_out, sram_data_out_valid, dropped_req
  );

  modport slave (
    input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    output sram_ready, sram_data_out, sram_data_out_valid, dropped_req
  );
endinterface

// File: rtl/sram_zbt_phy.sv
// Flow-through ZBT SRAM PHY: one request per cycle, reads return exactly 3 cycles after accept.
// A post-reset INIT period holds sram_ready low; requests seen then are flagged in dropped_req.
module sram_zbt_phy #(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 32,
  parameter int INIT_CYCLES = 16
) (
  input  logic                    sram_clock,
  input  logic                    reset,
  sram_zbt_phy_if.slave           bus,
  output logic [ADDR_WIDTH-1:0]   sram_addr_pad,
  output logic                    sram_ce_l,
  output logic                    sram_we_l,
  output logic [DATA_WIDTH/8-1:0] sram_bw_l,
  output logic                    sram_adv_ld_l,
  output logic                    sram_oe_l,
  output logic [DATA_WIDTH-1:0]   sram_dq_o,
  output logic                    sram_dq_t,
  input  logic [DATA_WIDTH-1:0]   sram_dq_i,
  output logic                    state_dbg
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [15:0] INIT_LOAD = 16'(INIT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] init_cnt, init_cnt_next;
  logic        ready, ready_next;

  logic                  accept;
  logic                  is_write;
  logic [2:0]            s_valid;
  logic [2:0]            s_write;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  dropped;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= INIT_LOAD;
      ready    <= 1'b0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
      ready    <= ready_next;
    end
  end

  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    ready_next    = 1'b0;
    case (state)
      INIT: begin
        if (init_cnt == 16'd0) begin
          state_next = RUN;
          ready_next = 1'b1;
        end else begin
          init_cnt_next = init_cnt - 16'd1;
        end
      end
      RUN: ready_next = 1'b1;
      default: state_next = INIT;
    endcase
  end

  assign accept   = bus.sram_addr_valid & ready;
  assign is_write = |bus.sram_write_mask;

  // Stage index k of s_valid/s_write describes the request accepted k+1 cycles ago.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      s_valid       <= '0;
      s_write       <= '0;
      wdata         <= '0;
      data_out      <= '0;
      dropped       <= 1'b0;
      sram_addr_pad <= '0;
      sram_ce_l     <= 1'b1;
      sram_we_l     <= 1'b1;
      sram_bw_l     <= '1;
      sram_oe_l     <= 1'b1;
      sram_dq_t     <= 1'b0;
      sram_dq_o     <= '0;
    end else begin
      s_valid   <= {s_valid[1:0], accept};
      s_write   <= {s_write[1:0], accept & is_write};
      sram_ce_l <= ~accept;
      sram_we_l <= ~(accept & is_write);
      sram_bw_l <= accept ? ~bus.sram_write_mask : '1;
      if (accept) begin
        sram_addr_pad <= bus.sram_addr;
        wdata         <= bus.sram_data_in;
      end
      // Only the second stage owns the DQ bus, so drive and output-enable never overlap.
      sram_dq_t <= s_valid[0] & s_write[0];
      sram_oe_l <= ~(s_valid[0] & ~s_write[0]);
      if (s_valid[0] & s_write[0]) sram_dq_o <= wdata;
      if (s_valid[1] & ~s_write[1]) data_out <= sram_dq_i;
      if (bus.sram_addr_valid & ~ready) dropped <= 1'b1;
    end
  end

  // Reset also masks a completion that would otherwise surface in the cycle reset is sampled.
  assign bus.sram_data_out_valid = s_valid[2] & ~s_write[2] & ~reset;
  assign bus.sram_data_out       = data_out;
  assign bus.sram_ready          = ready;
  assign bus.dropped_req         = dropped;
  assign sram_adv_ld_l           = 1'b0;
  assign state_dbg               = (state == RUN);

endmodule
